// File: rtl/regread_stage.sv
// regread_stage: register-read stage of the pipelined CPU.
// Issues reads to the 8x16 register file's synchronous read ports. It snoops the
// write-back port so that operands stay current in S1 and S2. Both operands and a
// pass-through payload are handed to execute over a valid/ready handshake.
module regread_stage #(
  parameter int PAYLOAD_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_ra,
  input  logic [2:0]           in_rb,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [2:0]           rf_raddr0,
  output logic [2:0]           rf_raddr1,
  input  logic [15:0]          rf_rdata0,
  input  logic [15:0]          rf_rdata1,
  input  logic                 wb_wen,
  input  logic [2:0]           wb_waddr,
  input  logic [15:0]          wb_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_a,
  output logic [15:0]          out_b,
  output logic [PAYLOAD_W-1:0] out_payload
);

  // A write-back hits a read when it targets the same nonzero register.
  function automatic logic wb_hit(input logic       wen,
                                  input logic [2:0] waddr,
                                  input logic [2:0] raddr);
    return wen && (waddr == raddr) && (raddr != 3'd0);
  endfunction

  // The S1 operand merges r0, a write captured at the read edge, and regfile data.
  function automatic logic [15:0] s1_operand(input logic [2:0]  ra,
                                             input logic        fwd,
                                             input logic [15:0] fwd_data,
                                             input logic [15:0] rdata);
    logic [15:0] val;
    if (ra == 3'd0) begin
      val = 16'd0;
    end else if (fwd) begin
      val = fwd_data;
    end else begin
      val = rdata;
    end
    return val;
  endfunction

  // The value loaded into S2 also absorbs a write landing on the S1->S2 edge.
  function automatic logic [15:0] s2_operand(input logic [2:0]  ra,
                                             input logic        wen,
                                             input logic [2:0]  waddr,
                                             input logic [15:0] wdata,
                                             input logic [15:0] op1);
    logic [15:0] val;
    if (ra == 3'd0) begin
      val = 16'd0;
    end else if (wen && (waddr == ra)) begin
      val = wdata;
    end else begin
      val = op1;
    end
    return val;
  endfunction

  // S1 state
  logic                 s1_valid_r;
  logic [2:0]           s1_ra_r;
  logic [2:0]           s1_rb_r;
  logic [PAYLOAD_W-1:0] s1_payload_r;
  logic                 fwd_a_r;
  logic [15:0]          fwd_a_data_r;
  logic                 fwd_b_r;
  logic [15:0]          fwd_b_data_r;

  // S2 source registers, kept so a held result can absorb later writes
  logic [2:0]           s2_ra_r;
  logic [2:0]           s2_rb_r;

  // Handshake and datapath nets
  logic                 s2_free_s;
  logic                 s1_adv_s;
  logic                 s1_load_s;
  logic                 s1_stall_s;
  logic [15:0]          a1_s;
  logic [15:0]          b1_s;
  logic [15:0]          s2_a_nxt_s;
  logic [15:0]          s2_b_nxt_s;
  logic                 hold_a_hit_s;
  logic                 hold_b_hit_s;

  // Handshake decode and read-address select (a stalled S1 keeps re-reading its sources)
  always_comb begin
    s2_free_s  = !out_valid || out_ready;
    s1_adv_s   = s1_valid_r && s2_free_s;
    s1_stall_s = s1_valid_r && !s2_free_s;
    in_ready   = !s1_valid_r || s2_free_s;
    s1_load_s  = in_valid && in_ready;
    if (s1_stall_s) begin
      rf_raddr0 = s1_ra_r;
      rf_raddr1 = s1_rb_r;
    end else begin
      rf_raddr0 = in_ra;
      rf_raddr1 = in_rb;
    end
  end

  // Operand values for S1 and the values S2 would load this cycle
  always_comb begin
    a1_s         = s1_operand(s1_ra_r, fwd_a_r, fwd_a_data_r, rf_rdata0);
    b1_s         = s1_operand(s1_rb_r, fwd_b_r, fwd_b_data_r, rf_rdata1);
    s2_a_nxt_s   = s2_operand(s1_ra_r, wb_wen, wb_waddr, wb_wdata, a1_s);
    s2_b_nxt_s   = s2_operand(s1_rb_r, wb_wen, wb_waddr, wb_wdata, b1_s);
    hold_a_hit_s = wb_hit(wb_wen, wb_waddr, s2_ra_r);
    hold_b_hit_s = wb_hit(wb_wen, wb_waddr, s2_rb_r);
  end

  // Capture any write that coincides with a read edge, since the regfile returns old data then
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_r      <= 1'b0;
      fwd_a_data_r <= 16'd0;
      fwd_b_r      <= 1'b0;
      fwd_b_data_r <= 16'd0;
    end else begin
      fwd_a_r      <= wb_hit(wb_wen, wb_waddr, rf_raddr0);
      fwd_a_data_r <= wb_wdata;
      fwd_b_r      <= wb_hit(wb_wen, wb_waddr, rf_raddr1);
      fwd_b_data_r <= wb_wdata;
    end
  end

  // S1 register: take a new instruction on accept, otherwise empty it when it advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s1_ra_r      <= 3'd0;
      s1_rb_r      <= 3'd0;
      s1_payload_r <= {PAYLOAD_W{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r   <= 1'b1;
      s1_ra_r      <= in_ra;
      s1_rb_r      <= in_rb;
      s1_payload_r <= in_payload;
    end else if (s1_adv_s) begin
      s1_valid_r   <= 1'b0;
    end
  end

  // S2 output register: load from S1, drain on out_ready, track writes while held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_a       <= 16'd0;
      out_b       <= 16'd0;
      out_payload <= {PAYLOAD_W{1'b0}};
      s2_ra_r     <= 3'd0;
      s2_rb_r     <= 3'd0;
    end else if (s1_adv_s) begin
      out_valid   <= 1'b1;
      out_a       <= s2_a_nxt_s;
      out_b       <= s2_b_nxt_s;
      out_payload <= s1_payload_r;
      s2_ra_r     <= s1_ra_r;
      s2_rb_r     <= s1_rb_r;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end else if (out_valid) begin
      if (hold_a_hit_s) begin
        out_a <= wb_wdata;
      end
      if (hold_b_hit_s) begin
        out_b <= wb_wdata;
      end
    end
  end

endmodule

// File: tb/tb_regread_stage.sv
// tb_regread_stage: regfile model plus scoreboard bench for regread_stage.
`timescale 1ns/1ps
module tb_regread_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ra;
  logic [2:0]  in_rb;
  logic [15:0] in_payload;
  logic [2:0]  rf_raddr0;
  logic [2:0]  rf_raddr1;
  logic [15:0] rf_rdata0;
  logic [15:0] rf_rdata1;
  logic        wb_wen;
  logic [2:0]  wb_waddr;
  logic [15:0] wb_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [15:0] out_payload;

  typedef struct {
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] pl;
    logic        wen;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] pl;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  vec_t tbl [8];
  int   checks;
  int   errors;
  int   cyc;
  int   streak;
  int   last_out_cyc;

  regread_stage #(.PAYLOAD_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ra       (in_ra),
    .in_rb       (in_rb),
    .in_payload  (in_payload),
    .rf_raddr0   (rf_raddr0),
    .rf_raddr1   (rf_raddr1),
    .rf_rdata0   (rf_rdata0),
    .rf_rdata1   (rf_rdata1),
    .wb_wen      (wb_wen),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_payload (out_payload)
  );

  always #5 clk = ~clk;

  // Register-file contents restored whenever rst is seen at a clock edge
  function automatic logic [15:0] rf_init(input int i);
    case (i)
      1:       return 16'h1111;
      2:       return 16'h2222;
      3:       return 16'h0000;
      4:       return 16'h4444;
      5:       return 16'h5555;
      6:       return 16'h6666;
      7:       return 16'h7777;
      default: return 16'h0000;
    endcase
  endfunction

  // Register file: synchronous reads, old data on same-edge write, r0 reads zero
  logic [15:0] rf_mem [8];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= rf_init(i);
    end else if (wb_wen && wb_waddr != 3'd0) begin
      rf_mem[wb_waddr] <= wb_wdata;
    end
    rf_rdata0 <= (rf_raddr0 == 3'd0) ? 16'h0000 : rf_mem[rf_raddr0];
    rf_rdata1 <= (rf_raddr1 == 3'd0) ? 16'h0000 : rf_mem[rf_raddr1];
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop/compare on output transfer, push the pending expectation on accept
  task automatic monitor();
    exp_t e;
    if (out_valid && out_ready) begin
      if (last_out_cyc == cyc - 1) streak++;
      else streak = 1;
      last_out_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: payload %h with empty scoreboard", out_payload);
      end else begin
        e = sb.pop_front();
        chk16("out_a", out_a, e.a);
        chk16("out_b", out_b, e.b);
        chk16("out_payload", out_payload, e.pl);
      end
    end
    if (in_valid && in_ready) sb.push_back(pend);
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic offer(input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] pl,
                       input logic [15:0] ea, input logic [15:0] eb);
    in_valid   = 1'b1;
    in_ra      = ra;
    in_rb      = rb;
    in_payload = pl;
    pend.a     = ea;
    pend.b     = eb;
    pend.pl    = pl;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; streak = 0; last_out_cyc = -10;
    rst = 1'b1; in_valid = 1'b0; in_ra = 3'd0; in_rb = 3'd0; in_payload = 16'h0000;
    wb_wen = 1'b0; wb_waddr = 3'd0; wb_wdata = 16'h0000; out_ready = 1'b1;
    pend.a = 16'h0000; pend.b = 16'h0000; pend.pl = 16'h0000;

    // Back-to-back stream; expectations include writes at each entry's S1->S2 edge
    tbl[0] = '{3'd1, 3'd2, 16'h0001, 1'b0, 3'd0, 16'h0000, 16'h1111, 16'h2222};
    tbl[1] = '{3'd5, 3'd6, 16'h0002, 1'b1, 3'd5, 16'h0BEE, 16'h0BEE, 16'h1234};
    tbl[2] = '{3'd6, 3'd7, 16'h0003, 1'b1, 3'd6, 16'h1234, 16'h1234, 16'hCAFE};
    tbl[3] = '{3'd3, 3'd0, 16'h0004, 1'b1, 3'd7, 16'hCAFE, 16'hA5A5, 16'h0000};
    tbl[4] = '{3'd7, 3'd7, 16'h0005, 1'b0, 3'd0, 16'h0000, 16'hCAFE, 16'hCAFE};
    tbl[5] = '{3'd1, 3'd4, 16'h0006, 1'b1, 3'd1, 16'hBEEF, 16'hBEEF, 16'h0F0F};
    tbl[6] = '{3'd2, 3'd1, 16'h0007, 1'b1, 3'd4, 16'h0F0F, 16'h9999, 16'hBEEF};
    tbl[7] = '{3'd4, 3'd2, 16'h0008, 1'b1, 3'd2, 16'h9999, 16'h0F0F, 16'h9999};

    // Reset state
    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk16("rst_out_a", out_a, 16'h0000);
    chk16("rst_out_b", out_b, 16'h0000);
    chk16("rst_out_payload", out_payload, 16'h0000);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Basic read with latency and single-cycle output
    offer(3'd1, 3'd2, 16'hABCD, 16'h1111, 16'h2222);
    cycle();
    in_valid = 1'b0;
    chk1("lat_after_N", out_valid, 1'b0);
    cycle();
    chk1("lat_after_N1", out_valid, 1'b1);
    cycle();
    chk1("lat_after_N2", out_valid, 1'b0);
    idle(2);

    // Same-edge forward: r3 written as ra=3 is accepted
    offer(3'd3, 3'd1, 16'h2A2A, 16'h5A5A, 16'h1111);
    wb_wen = 1'b1; wb_waddr = 3'd3; wb_wdata = 16'h5A5A;
    cycle();
    wb_wen = 1'b0;
    idle(3);

    // Write on the S1->S2 edge
    offer(3'd3, 3'd4, 16'h2B2B, 16'hA5A5, 16'h4444);
    cycle();
    in_valid = 1'b0;
    wb_wen = 1'b1; wb_waddr = 3'd3; wb_wdata = 16'hA5A5;
    cycle();
    wb_wen = 1'b0;
    idle(3);

    // Register 0 ignores writes
    offer(3'd0, 3'd0, 16'h3C3C, 16'h0000, 16'h0000);
    wb_wen = 1'b1; wb_waddr = 3'd0; wb_wdata = 16'hFFFF;
    cycle();
    in_valid = 1'b0;
    cycle();
    wb_wen = 1'b0;
    idle(3);

    // Streaming table
    for (int i = 0; i < 8; i++) begin
      offer(tbl[i].ra, tbl[i].rb, tbl[i].pl, tbl[i].ea, tbl[i].eb);
      wb_wen = tbl[i].wen; wb_waddr = tbl[i].wa; wb_wdata = tbl[i].wd;
      chk1("stream_in_ready", in_ready, 1'b1);
      cycle();
    end
    wb_wen = 1'b0;
    idle(4);
    chki("stream_streak", streak, 8);

    // Backpressure: 4 held cycles, r2 written during the hold
    out_ready = 1'b0;
    offer(3'd1, 3'd2, 16'hB001, 16'hBEEF, 16'h7777);
    cycle();
    offer(3'd2, 3'd3, 16'hB002, 16'h7777, 16'hA5A5);
    cycle();
    chk1("bp_in_ready_low", in_ready, 1'b0);
    chk1("bp_out_valid", out_valid, 1'b1);
    chk16("bp_out_b_before", out_b, 16'h9999);
    offer(3'd5, 3'd6, 16'hB003, 16'h0BEE, 16'h1234);
    wb_wen = 1'b1; wb_waddr = 3'd2; wb_wdata = 16'h7777;
    cycle();
    wb_wen = 1'b0;
    chk16("bp_out_b_updated", out_b, 16'h7777);
    chk16("bp_out_a_held", out_a, 16'hBEEF);
    chk1("bp_out_valid_held", out_valid, 1'b1);
    cycle();
    chk1("bp_in_ready_still_low", in_ready, 1'b0);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    idle(4);
    chki("bp_release_streak", streak, 3);

    // Reset with S1 and S2 full
    out_ready = 1'b0;
    offer(3'd4, 3'd5, 16'hD001, 16'h0F0F, 16'h0BEE);
    cycle();
    offer(3'd6, 3'd7, 16'hD002, 16'h1234, 16'hCAFE);
    cycle();
    in_valid = 1'b0;
    chk1("pre_rst_out_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk16("mid_rst_out_a", out_a, 16'h0000);
    chk16("mid_rst_out_b", out_b, 16'h0000);
    chk16("mid_rst_out_payload", out_payload, 16'h0000);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(2);
    chk1("post_rst_no_output", out_valid, 1'b0);
    offer(3'd1, 3'd2, 16'hC0DE, 16'h1111, 16'h2222);
    cycle();
    in_valid = 1'b0;
    chk1("post_rst_lat_N", out_valid, 1'b0);
    cycle();
    chk1("post_rst_lat_N1", out_valid, 1'b1);
    cycle();
    chk1("post_rst_lat_N2", out_valid, 1'b0);
    idle(3);

    chki("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
